// File: rtl/spu_hazard_ctrl.sv
// Dual-issue operand hazard controller for the SPU-Lite even/odd pipes.
// Tracks in-flight destinations per pipe and holds issue until producers become forwardable.
module spu_hazard_ctrl #(
  parameter int ADDR_WD = 7,
  parameter int DEPTH   = 7,
  parameter int CNT_WD  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,

  input  logic               ev_valid,
  input  logic [ADDR_WD-1:0] ev_ra,
  input  logic [ADDR_WD-1:0] ev_rb,
  input  logic [ADDR_WD-1:0] ev_rc,
  input  logic               ev_ra_use,
  input  logic               ev_rb_use,
  input  logic               ev_rc_use,
  input  logic [ADDR_WD-1:0] ev_rt,
  input  logic [2:0]         ev_unit,
  output logic               ev_ready,

  input  logic               od_valid,
  input  logic [ADDR_WD-1:0] od_ra,
  input  logic [ADDR_WD-1:0] od_rb,
  input  logic [ADDR_WD-1:0] od_rc,
  input  logic               od_ra_use,
  input  logic               od_rb_use,
  input  logic               od_rc_use,
  input  logic [ADDR_WD-1:0] od_rt,
  input  logic [2:0]         od_unit,
  output logic               od_ready,

  output logic [ADDR_WD-1:0] rf_addr_s2_ep,
  output logic [ADDR_WD-1:0] rf_addr_s3_ep,
  output logic [ADDR_WD-1:0] rf_addr_s4_ep,
  output logic [ADDR_WD-1:0] rf_addr_s5_ep,
  output logic [ADDR_WD-1:0] rf_addr_s6_ep,
  output logic [ADDR_WD-1:0] rf_addr_s7_ep,
  output logic [ADDR_WD-1:0] rf_addr_s2_op,
  output logic [ADDR_WD-1:0] rf_addr_s3_op,
  output logic [ADDR_WD-1:0] rf_addr_s4_op,
  output logic [ADDR_WD-1:0] rf_addr_s5_op,
  output logic [ADDR_WD-1:0] rf_addr_s6_op,
  output logic [ADDR_WD-1:0] rf_addr_s7_op,
  output logic [2:0]         rf_idx_s2_ep,
  output logic [2:0]         rf_idx_s3_ep,
  output logic [2:0]         rf_idx_s4_ep,
  output logic [2:0]         rf_idx_s5_ep,
  output logic [2:0]         rf_idx_s6_ep,
  output logic [2:0]         rf_idx_s7_ep,
  output logic [2:0]         rf_idx_s2_op,
  output logic [2:0]         rf_idx_s3_op,
  output logic [2:0]         rf_idx_s4_op,
  output logic [2:0]         rf_idx_s5_op,
  output logic [2:0]         rf_idx_s6_op,
  output logic [2:0]         rf_idx_s7_op,

  output logic [CNT_WD-1:0]  stall_cnt
);

  // Stage at which each unit's result first becomes forwardable; unknown units wait to s7.
  function automatic logic [2:0] ep_ready_stage(input logic [2:0] u);
    logic [2:0] r;
    case (u)
      3'd1:    r = 3'd2;
      3'd2:    r = 3'd3;
      3'd4:    r = 3'd3;
      3'd3:    r = 3'd6;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] op_ready_stage(input logic [2:0] u);
    logic [2:0] r;
    case (u)
      3'd5:    r = 3'd4;
      3'd6:    r = 3'd6;
      default: r = 3'd7;
    endcase
    return r;
  endfunction

  function automatic logic src_hit(
    input logic [ADDR_WD-1:0] a,
    input logic [ADDR_WD-1:0] ra, input logic ra_use,
    input logic [ADDR_WD-1:0] rb, input logic rb_use,
    input logic [ADDR_WD-1:0] rc, input logic rc_use
  );
    return (ra_use && ra == a) || (rb_use && rb == a) || (rc_use && rc == a);
  endfunction

  logic [ADDR_WD-1:0] ep_addr_reg [1:DEPTH];
  logic [2:0]         ep_idx_reg  [1:DEPTH];
  logic [ADDR_WD-1:0] op_addr_reg [1:DEPTH];
  logic [2:0]         op_idx_reg  [1:DEPTH];
  logic [CNT_WD-1:0]  stall_cnt_reg;

  logic [DEPTH:1] ep_pend;
  logic [DEPTH:1] op_pend;
  logic           ev_haz;
  logic           od_haz;
  logic           pair_block;
  logic           ev_rdy;
  logic           od_rdy;
  logic           ev_issue;
  logic           od_issue;
  logic           stall_now;

  genvar gi;
  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_pend
      assign ep_pend[gi] = (ep_idx_reg[gi] != 3'd0) &&
                           (4'(gi) < {1'b0, ep_ready_stage(ep_idx_reg[gi])});
      assign op_pend[gi] = (op_idx_reg[gi] != 3'd0) &&
                           (4'(gi) < {1'b0, op_ready_stage(op_idx_reg[gi])});
    end
  endgenerate

  always_comb begin
    ev_haz = 1'b0;
    od_haz = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (ep_pend[k]) begin
        ev_haz |= src_hit(ep_addr_reg[k], ev_ra, ev_ra_use, ev_rb, ev_rb_use, ev_rc, ev_rc_use);
        od_haz |= src_hit(ep_addr_reg[k], od_ra, od_ra_use, od_rb, od_rb_use, od_rc, od_rc_use);
      end
      if (op_pend[k]) begin
        ev_haz |= src_hit(op_addr_reg[k], ev_ra, ev_ra_use, ev_rb, ev_rb_use, ev_rc, ev_rc_use);
        od_haz |= src_hit(op_addr_reg[k], od_ra, od_ra_use, od_rb, od_rb_use, od_rc, od_rc_use);
      end
    end
  end

  // The even slot is older: the odd slot may not read or overwrite its destination this cycle.
  assign pair_block = ev_valid && (ev_unit != 3'd0) &&
                      (src_hit(ev_rt, od_ra, od_ra_use, od_rb, od_rb_use, od_rc, od_rc_use) ||
                       ((od_unit != 3'd0) && (od_rt == ev_rt)));

  assign ev_rdy = !flush && !rst && !ev_haz;
  assign od_rdy = !flush && !rst && !od_haz && !pair_block && !(ev_valid && !ev_rdy);

  assign ev_ready  = ev_rdy;
  assign od_ready  = od_rdy;
  assign ev_issue  = ev_valid && ev_rdy;
  assign od_issue  = od_valid && od_rdy;
  assign stall_now = (ev_valid && !ev_rdy) || (od_valid && !od_rdy);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int k = 1; k <= DEPTH; k++) begin
        ep_addr_reg[k] <= '0;
        ep_idx_reg[k]  <= 3'd0;
        op_addr_reg[k] <= '0;
        op_idx_reg[k]  <= 3'd0;
      end
    end else begin
      ep_addr_reg[1] <= ev_issue ? ev_rt   : '0;
      ep_idx_reg[1]  <= ev_issue ? ev_unit : 3'd0;
      op_addr_reg[1] <= od_issue ? od_rt   : '0;
      op_idx_reg[1]  <= od_issue ? od_unit : 3'd0;
      for (int k = 2; k <= DEPTH; k++) begin
        ep_addr_reg[k] <= ep_addr_reg[k-1];
        ep_idx_reg[k]  <= ep_idx_reg[k-1];
        op_addr_reg[k] <= op_addr_reg[k-1];
        op_idx_reg[k]  <= op_idx_reg[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_now && (stall_cnt_reg != {CNT_WD{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  assign rf_addr_s2_ep = ep_addr_reg[2];
  assign rf_addr_s3_ep = ep_addr_reg[3];
  assign rf_addr_s4_ep = ep_addr_reg[4];
  assign rf_addr_s5_ep = ep_addr_reg[5];
  assign rf_addr_s6_ep = ep_addr_reg[6];
  assign rf_addr_s7_ep = ep_addr_reg[7];
  assign rf_addr_s2_op = op_addr_reg[2];
  assign rf_addr_s3_op = op_addr_reg[3];
  assign rf_addr_s4_op = op_addr_reg[4];
  assign rf_addr_s5_op = op_addr_reg[5];
  assign rf_addr_s6_op = op_addr_reg[6];
  assign rf_addr_s7_op = op_addr_reg[7];
  assign rf_idx_s2_ep  = ep_idx_reg[2];
  assign rf_idx_s3_ep  = ep_idx_reg[3];
  assign rf_idx_s4_ep  = ep_idx_reg[4];
  assign rf_idx_s5_ep  = ep_idx_reg[5];
  assign rf_idx_s6_ep  = ep_idx_reg[6];
  assign rf_idx_s7_ep  = ep_idx_reg[7];
  assign rf_idx_s2_op  = op_idx_reg[2];
  assign rf_idx_s3_op  = op_idx_reg[3];
  assign rf_idx_s4_op  = op_idx_reg[4];
  assign rf_idx_s5_op  = op_idx_reg[5];
  assign rf_idx_s6_op  = op_idx_reg[6];
  assign rf_idx_s7_op  = op_idx_reg[7];

endmodule

// File: tb/tb_spu_hazard_ctrl.sv
// Directed bench for spu_hazard_ctrl: hazard timing, pairing, flush and counter saturation.
module tb_spu_hazard_ctrl;
  localparam int AW = 7;

  logic          clk, rst, flush;
  logic          ev_valid, ev_ra_use, ev_rb_use, ev_rc_use;
  logic [AW-1:0] ev_ra, ev_rb, ev_rc, ev_rt;
  logic [2:0]    ev_unit;
  logic          od_valid, od_ra_use, od_rb_use, od_rc_use;
  logic [AW-1:0] od_ra, od_rb, od_rc, od_rt;
  logic [2:0]    od_unit;
  logic          ev_ready, od_ready, ev_ready_s, od_ready_s;
  logic [AW-1:0] a_ep [2:7];
  logic [AW-1:0] a_op [2:7];
  logic [2:0]    i_ep [2:7];
  logic [2:0]    i_op [2:7];
  logic [AW-1:0] a_ep_s [2:7];
  logic [AW-1:0] a_op_s [2:7];
  logic [2:0]    i_ep_s [2:7];
  logic [2:0]    i_op_s [2:7];
  logic [31:0]   stall_cnt;
  logic [3:0]    stall_cnt_s;

  int n_chk  = 0;
  int n_pass = 0;

  spu_hazard_ctrl #(.ADDR_WD(AW), .DEPTH(7), .CNT_WD(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ev_valid(ev_valid), .ev_ra(ev_ra), .ev_rb(ev_rb), .ev_rc(ev_rc),
    .ev_ra_use(ev_ra_use), .ev_rb_use(ev_rb_use), .ev_rc_use(ev_rc_use),
    .ev_rt(ev_rt), .ev_unit(ev_unit), .ev_ready(ev_ready),
    .od_valid(od_valid), .od_ra(od_ra), .od_rb(od_rb), .od_rc(od_rc),
    .od_ra_use(od_ra_use), .od_rb_use(od_rb_use), .od_rc_use(od_rc_use),
    .od_rt(od_rt), .od_unit(od_unit), .od_ready(od_ready),
    .rf_addr_s2_ep(a_ep[2]), .rf_addr_s3_ep(a_ep[3]), .rf_addr_s4_ep(a_ep[4]),
    .rf_addr_s5_ep(a_ep[5]), .rf_addr_s6_ep(a_ep[6]), .rf_addr_s7_ep(a_ep[7]),
    .rf_addr_s2_op(a_op[2]), .rf_addr_s3_op(a_op[3]), .rf_addr_s4_op(a_op[4]),
    .rf_addr_s5_op(a_op[5]), .rf_addr_s6_op(a_op[6]), .rf_addr_s7_op(a_op[7]),
    .rf_idx_s2_ep(i_ep[2]), .rf_idx_s3_ep(i_ep[3]), .rf_idx_s4_ep(i_ep[4]),
    .rf_idx_s5_ep(i_ep[5]), .rf_idx_s6_ep(i_ep[6]), .rf_idx_s7_ep(i_ep[7]),
    .rf_idx_s2_op(i_op[2]), .rf_idx_s3_op(i_op[3]), .rf_idx_s4_op(i_op[4]),
    .rf_idx_s5_op(i_op[5]), .rf_idx_s6_op(i_op[6]), .rf_idx_s7_op(i_op[7]),
    .stall_cnt(stall_cnt)
  );

  // Narrow-counter build driven by the same stimulus, for saturation.
  spu_hazard_ctrl #(.ADDR_WD(AW), .DEPTH(7), .CNT_WD(4)) dut_s (
    .clk(clk), .rst(rst), .flush(flush),
    .ev_valid(ev_valid), .ev_ra(ev_ra), .ev_rb(ev_rb), .ev_rc(ev_rc),
    .ev_ra_use(ev_ra_use), .ev_rb_use(ev_rb_use), .ev_rc_use(ev_rc_use),
    .ev_rt(ev_rt), .ev_unit(ev_unit), .ev_ready(ev_ready_s),
    .od_valid(od_valid), .od_ra(od_ra), .od_rb(od_rb), .od_rc(od_rc),
    .od_ra_use(od_ra_use), .od_rb_use(od_rb_use), .od_rc_use(od_rc_use),
    .od_rt(od_rt), .od_unit(od_unit), .od_ready(od_ready_s),
    .rf_addr_s2_ep(a_ep_s[2]), .rf_addr_s3_ep(a_ep_s[3]), .rf_addr_s4_ep(a_ep_s[4]),
    .rf_addr_s5_ep(a_ep_s[5]), .rf_addr_s6_ep(a_ep_s[6]), .rf_addr_s7_ep(a_ep_s[7]),
    .rf_addr_s2_op(a_op_s[2]), .rf_addr_s3_op(a_op_s[3]), .rf_addr_s4_op(a_op_s[4]),
    .rf_addr_s5_op(a_op_s[5]), .rf_addr_s6_op(a_op_s[6]), .rf_addr_s7_op(a_op_s[7]),
    .rf_idx_s2_ep(i_ep_s[2]), .rf_idx_s3_ep(i_ep_s[3]), .rf_idx_s4_ep(i_ep_s[4]),
    .rf_idx_s5_ep(i_ep_s[5]), .rf_idx_s6_ep(i_ep_s[6]), .rf_idx_s7_ep(i_ep_s[7]),
    .rf_idx_s2_op(i_op_s[2]), .rf_idx_s3_op(i_op_s[3]), .rf_idx_s4_op(i_op_s[4]),
    .rf_idx_s5_op(i_op_s[5]), .rf_idx_s6_op(i_op_s[6]), .rf_idx_s7_op(i_op_s[7]),
    .stall_cnt(stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s ok   value=%0h", tag, got);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 1'b0;
    ev_valid = 1'b0; ev_ra = '0; ev_rb = '0; ev_rc = '0; ev_rt = '0; ev_unit = 3'd0;
    ev_ra_use = 1'b0; ev_rb_use = 1'b0; ev_rc_use = 1'b0;
    od_valid = 1'b0; od_ra = '0; od_rb = '0; od_rc = '0; od_rt = '0; od_unit = 3'd0;
    od_ra_use = 1'b0; od_rb_use = 1'b0; od_rc_use = 1'b0;
  endtask

  function automatic logic [2:0] idx_or();
    logic [2:0] r;
    r = 3'd0;
    for (int k = 2; k <= 7; k++) r |= i_ep[k] | i_op[k];
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    idle();

    // Reset state.
    next_cycle();
    next_cycle();
    settle();
    chk("rst_ev_ready", ev_ready, 1'b0);
    chk("rst_od_ready", od_ready, 1'b0);
    chk("rst_idx", idx_or(), 3'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    next_cycle();
    rst = 1'b0;
    settle();
    chk("idle_ev_ready", ev_ready, 1'b1);
    chk("idle_od_ready", od_ready, 1'b1);

    // Even unit-1 producer rt=5, dependent one cycle later.
    next_cycle();
    ev_valid = 1'b1; ev_rt = 7'd5; ev_unit = 3'd1;
    settle();
    chk("u1_prod_issue", ev_ready, 1'b1);
    next_cycle();
    ev_rt = 7'd6; ev_unit = 3'd0; ev_ra = 7'd5; ev_ra_use = 1'b1;
    settle();
    chk("u1_dep_t1", ev_ready, 1'b0);
    next_cycle();
    settle();
    chk("u1_dep_t2", ev_ready, 1'b1);
    chk("u1_idx_s2", i_ep[2], 3'd1);
    chk("u1_addr_s2", a_ep[2], 7'd5);
    next_cycle();
    idle();
    settle();
    chk("u1_stall", stall_cnt, 32'd1);

    // Even unit-3 producer rt=9, odd consumer waits five cycles.
    next_cycle();
    ev_valid = 1'b1; ev_rt = 7'd9; ev_unit = 3'd3;
    settle();
    chk("u3_prod_issue", ev_ready, 1'b1);
    next_cycle();
    idle();
    od_valid = 1'b1; od_rb = 7'd9; od_rb_use = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      settle();
      chk($sformatf("u3_hold_t%0d", c), od_ready, 1'b0);
      next_cycle();
    end
    settle();
    chk("u3_dep_t6", od_ready, 1'b1);
    chk("u3_idx_s6", i_ep[6], 3'd3);
    chk("u3_addr_s6", a_ep[6], 7'd9);
    next_cycle();
    idle();
    settle();
    chk("u3_stall", stall_cnt, 32'd6);

    // Same-cycle pair: odd reads the even destination; unit-1 result is pending at s1.
    next_cycle();
    ev_valid = 1'b1; ev_rt = 7'd12; ev_unit = 3'd1;
    od_valid = 1'b1; od_ra = 7'd12; od_ra_use = 1'b1; od_rt = 7'd13; od_unit = 3'd5;
    settle();
    chk("pair_ev_ready", ev_ready, 1'b1);
    chk("pair_od_block", od_ready, 1'b0);
    next_cycle();
    ev_valid = 1'b0; ev_rt = '0; ev_unit = 3'd0;
    settle();
    chk("pair_od_s1", od_ready, 1'b0);
    next_cycle();
    settle();
    chk("pair_od_s2", od_ready, 1'b1);
    next_cycle();
    idle();
    settle();
    chk("pair_stall", stall_cnt, 32'd8);

    // Odd unit-5 producer rt=20, flush while even consumer waits.
    next_cycle();
    od_valid = 1'b1; od_rt = 7'd20; od_unit = 3'd5;
    settle();
    chk("flush_prod", od_ready, 1'b1);
    next_cycle();
    idle();
    ev_valid = 1'b1; ev_ra = 7'd20; ev_ra_use = 1'b1;
    settle();
    chk("flush_wait", ev_ready, 1'b0);
    next_cycle();
    flush = 1'b1;
    settle();
    chk("flush_ev_ready", ev_ready, 1'b0);
    chk("flush_od_ready", od_ready, 1'b0);
    next_cycle();
    flush = 1'b0;
    settle();
    chk("flush_idx", idx_or(), 3'd0);
    chk("flush_issue", ev_ready, 1'b1);
    next_cycle();
    idle();
    settle();
    chk("flush_stall", stall_cnt, 32'd10);

    // Illegal even unit (5) waits to s7.
    next_cycle();
    ev_valid = 1'b1; ev_rt = 7'd30; ev_unit = 3'd5;
    settle();
    chk("ill_prod", ev_ready, 1'b1);
    next_cycle();
    ev_rt = '0; ev_unit = 3'd0; ev_rb = 7'd30; ev_rb_use = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      settle();
      chk($sformatf("ill_hold_t%0d", c), ev_ready, 1'b0);
      next_cycle();
    end
    settle();
    chk("ill_dep_t7", ev_ready, 1'b1);
    chk("ill_idx_s7", i_ep[7], 3'd5);
    chk("ill_addr_s7", a_ep[7], 7'd30);
    next_cycle();
    idle();
    settle();
    chk("ill_stall", stall_cnt, 32'd16);

    // Register 0 source against bubbles never stalls.
    next_cycle();
    ev_valid = 1'b1; ev_ra = 7'd0; ev_ra_use = 1'b1; ev_rc = 7'd0; ev_rc_use = 1'b1;
    settle();
    chk("r0_bubble", ev_ready, 1'b1);

    // Same destination in both slots blocks the odd slot.
    next_cycle();
    idle();
    ev_valid = 1'b1; ev_rt = 7'd40; ev_unit = 3'd1;
    od_valid = 1'b1; od_rt = 7'd40; od_unit = 3'd6;
    settle();
    chk("waw_ev_ready", ev_ready, 1'b1);
    chk("waw_od_block", od_ready, 1'b0);
    next_cycle();
    idle();
    settle();
    chk("waw_stall", stall_cnt, 32'd17);

    // Saturation of the 4-bit counter over a 20-cycle stall.
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    flush = 1'b1; ev_valid = 1'b1;
    for (int c = 0; c < 20; c++) next_cycle();
    settle();
    chk("sat_small", stall_cnt_s, 4'd15);
    chk("sat_wide", stall_cnt, 32'd20);
    next_cycle();
    settle();
    chk("sat_hold", stall_cnt_s, 4'd15);
    idle();
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
